// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package loader_pkg;

  localparam int ADDR_WIDTH  = 8;
  localparam int INSTR_WIDTH = 10;
  localparam int PAD_WIDTH   = 6;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    LO,
    HI,
    WRITE,
    DONE,
    ERR
  } loader_state_t;

  // True when any of the unused upper bits of an instruction high byte are set.
  function automatic logic pad_nonzero(input logic [7:0] hi_byte);
    return hi_byte[7:8-PAD_WIDTH] != '0;
  endfunction

endpackage

// File: rtl/flopr.sv
// Generic resettable register with synchronous active-high reset.
module flopr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= d;
  end

endmodule

// File: rtl/program_loader_assembler.sv
// Captures the low byte of an instruction and registers the full 10-bit word
// once the high byte arrives.
module instr_assembler
  import loader_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   lo_load,
  input  logic [7:0]             lo_data,
  input  logic                   hi_load,
  input  logic [1:0]             hi_bits,
  output logic [INSTR_WIDTH-1:0] instruct
);

  logic [7:0]             lo_q;
  logic [7:0]             lo_d;
  logic [INSTR_WIDTH-1:0] instr_d;

  // Both registers hold their value unless their load strobe is high.
  assign lo_d    = lo_load ? lo_data : lo_q;
  assign instr_d = hi_load ? {hi_bits, lo_q} : instruct;

  flopr #(.WIDTH(8)) lo_reg (
    .clk   (clk),
    .reset (reset),
    .d     (lo_d),
    .q     (lo_q)
  );

  flopr #(.WIDTH(INSTR_WIDTH)) instr_reg (
    .clk   (clk),
    .reset (reset),
    .d     (instr_d),
    .q     (instruct)
  );

endmodule

// File: rtl/program_loader.sv
// Streams a byte-encoded program into instruction memory and holds the
// processor in reset until the whole program has been written.
module program_loader
  import loader_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 8'h00,
  parameter bit                    STRICT_PAD = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  output logic                   byte_ready,
  output logic                   memWrite,
  output logic [ADDR_WIDTH-1:0]  adr,
  output logic [INSTR_WIDTH-1:0] instruct,
  output logic                   cpu_reset,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  loader_state_t         state;
  logic [7:0]            n_total;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  xfer;
  logic                  pad_err;
  logic                  lo_load;
  logic                  hi_load;
  logic                  last;

  assign xfer    = byte_valid & byte_ready;
  assign pad_err = STRICT_PAD && pad_nonzero(byte_data);
  assign lo_load = xfer && (state == LO);
  assign hi_load = xfer && (state == HI) && !pad_err;
  // A count of zero wraps to 255 here, which makes it mean 256 instructions.
  assign last    = (idx == n_total - 8'd1);

  instr_assembler assembler (
    .clk      (clk),
    .reset    (reset),
    .lo_load  (lo_load),
    .lo_data  (byte_data),
    .hi_load  (hi_load),
    .hi_bits  (byte_data[1:0]),
    .instruct (instruct)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      n_total    <= '0;
      idx        <= '0;
      adr        <= '0;
      memWrite   <= 1'b0;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      cpu_reset  <= 1'b1;
    end else begin
      memWrite <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state      <= COUNT;
            byte_ready <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_reset  <= 1'b1;
          end
        end
        COUNT: begin
          if (xfer) begin
            n_total <= byte_data;
            idx     <= '0;
            state   <= LO;
          end
        end
        LO: begin
          if (xfer) state <= HI;
        end
        HI: begin
          if (xfer) begin
            byte_ready <= 1'b0;
            if (pad_err) begin
              state <= ERR;
              busy  <= 1'b0;
              error <= 1'b1;
            end else begin
              state    <= WRITE;
              memWrite <= 1'b1;
              adr      <= BASE_ADDR + idx;
            end
          end
        end
        WRITE: begin
          idx <= idx + 8'd1;
          if (last) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            cpu_reset <= 1'b0;
          end else begin
            state      <= LO;
            byte_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Drives two loaders (base 00/strict and base FE/lenient) with the same byte
// stream and checks both against a byte-counting reference model every cycle.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       byte_valid;
  logic [7:0] byte_data;

  logic       rdy0, mw0, cpur0, busy0, done0, err0;
  logic [7:0] adr0;
  logic [9:0] ins0;
  logic       rdy1, mw1, cpur1, busy1, done1, err1;
  logic [7:0] adr1;
  logic [9:0] ins1;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;
  int cyc      = 0;
  int dut_writes1 = 0;

  typedef struct {
    logic [7:0] adr;
    logic [9:0] ins;
    int         cyc;
  } wr_t;

  wr_t log0[$];
  wr_t log1[$];

  bit         m_active[2], m_have_count[2], m_have_lo[2], m_write_now[2];
  bit         m_done[2], m_error[2];
  int         m_total[2], m_written[2], m_done_cyc[2];
  logic [7:0] m_lo[2], m_adr[2];
  logic [9:0] m_ins[2];

  always #5 clk = ~clk;

  program_loader #(.BASE_ADDR(8'h00), .STRICT_PAD(1'b1)) dut0 (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(rdy0), .memWrite(mw0), .adr(adr0),
    .instruct(ins0), .cpu_reset(cpur0), .busy(busy0), .done(done0), .error(err0)
  );

  program_loader #(.BASE_ADDR(8'hFE), .STRICT_PAD(1'b0)) dut1 (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(rdy1), .memWrite(mw1), .adr(adr1),
    .instruct(ins1), .cpu_reset(cpur1), .busy(busy1), .done(done1), .error(err1)
  );

  // Reference model: tracks bytes consumed and instructions written per lane.
  always @(posedge clk) begin
    cyc++;
    for (int l = 0; l < 2; l++) begin
      if (reset) begin
        m_active[l] = 0; m_have_count[l] = 0; m_have_lo[l] = 0;
        m_write_now[l] = 0; m_done[l] = 0; m_error[l] = 0;
        m_total[l] = 0; m_written[l] = 0; m_adr[l] = 8'h00; m_ins[l] = 10'h000;
      end else if (m_write_now[l]) begin
        m_write_now[l] = 0;
        m_written[l]++;
        if (m_written[l] == m_total[l]) begin
          m_active[l] = 0;
          m_done[l] = 1;
          m_done_cyc[l] = cyc;
        end
      end else if (!m_active[l]) begin
        if (start) begin
          m_active[l] = 1; m_have_count[l] = 0; m_have_lo[l] = 0;
          m_done[l] = 0; m_error[l] = 0; m_written[l] = 0;
        end
      end else if (byte_valid) begin
        if (!m_have_count[l]) begin
          m_total[l] = (byte_data == 8'h00) ? 256 : int'(byte_data);
          m_have_count[l] = 1;
        end else if (!m_have_lo[l]) begin
          m_lo[l] = byte_data;
          m_have_lo[l] = 1;
        end else begin
          m_have_lo[l] = 0;
          if (l == 0 && byte_data[7:2] != 6'd0) begin
            m_active[l] = 0;
            m_error[l] = 1;
          end else begin
            wr_t w;
            m_write_now[l] = 1;
            m_adr[l] = 8'((l == 0 ? 0 : 254) + m_written[l]);
            m_ins[l] = {byte_data[1:0], m_lo[l]};
            w.adr = m_adr[l];
            w.ins = m_ins[l];
            w.cyc = cyc;
            if (l == 0) log0.push_back(w);
            else        log1.push_back(w);
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at t=%0t got=%0h exp=%0h", name, $time, act, exp);
    end
  endtask

  task automatic compare_lane(input int l, input logic rdy, input logic mw, input logic [7:0] adr,
                              input logic [9:0] ins, input logic cpur, input logic bsy,
                              input logic dn, input logic er);
    string p;
    p = (l == 0) ? "lane0" : "lane1";
    checkOutput({p, " byte_ready"}, rdy, m_active[l] && !m_write_now[l]);
    checkOutput({p, " memWrite"}, mw, m_write_now[l]);
    checkOutput({p, " adr"}, adr, m_adr[l]);
    checkOutput({p, " instruct"}, ins, m_ins[l]);
    checkOutput({p, " cpu_reset"}, cpur, !m_done[l]);
    checkOutput({p, " busy"}, bsy, m_active[l]);
    checkOutput({p, " done"}, dn, m_done[l]);
    checkOutput({p, " error"}, er, m_error[l]);
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      compare_lane(0, rdy0, mw0, adr0, ins0, cpur0, busy0, done0, err0);
      compare_lane(1, rdy1, mw1, adr1, ins1, cpur1, busy1, done1, err1);
    end
    if (mw1) dut_writes1++;
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers one byte after an optional idle gap and waits (bounded) for acceptance.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    for (int k = 0; k < 64; k++) begin
      if (rdy0) break;
      @(negedge clk);
    end
    checkOutput("byte accepted", rdy0, 1'b1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_basic(input int gap);
    applyStimulus(8'h02, gap);
    applyStimulus(8'h34, gap);
    applyStimulus(8'h01, gap);
    applyStimulus(8'h7F, gap);
    applyStimulus(8'h02, gap);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(negedge clk);
    check_en = 1'b1;
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] basic load");
    log0.delete(); log1.delete();
    pulse_start();
    send_basic(0);
    checkOutput("basic count", log0.size(), 2);
    checkOutput("basic adr0", log0[0].adr, 8'h00);
    checkOutput("basic ins0", log0[0].ins, 10'h134);
    checkOutput("basic adr1", log0[1].adr, 8'h01);
    checkOutput("basic ins1", log0[1].ins, 10'h27F);
    checkOutput("basic spacing", log0[1].cyc - log0[0].cyc, 3);
    checkOutput("basic done lag", m_done_cyc[0] - log0[1].cyc, 1);
    checkOutput("basic fe adr0", log1[0].adr, 8'hFE);
    checkOutput("basic fe adr1", log1[1].adr, 8'hFF);

    $display("[TB] stalled reload from DONE");
    log0.delete(); log1.delete();
    pulse_start();
    send_basic(4);
    checkOutput("stall count", log0.size(), 2);
    checkOutput("stall ins1", log0[1].ins, 10'h27F);

    $display("[TB] start ignored during LO");
    log0.delete(); log1.delete();
    pulse_start();
    applyStimulus(8'h01, 0);
    pulse_start();
    applyStimulus(8'h55, 1);
    applyStimulus(8'h03, 0);
    repeat (3) @(negedge clk);
    checkOutput("ignore count", log0.size(), 1);
    checkOutput("ignore ins", log0[0].ins, 10'h355);

    $display("[TB] pad error then recovery");
    log0.delete(); log1.delete();
    pulse_start();
    applyStimulus(8'h01, 0);
    applyStimulus(8'hAA, 0);
    applyStimulus(8'h04, 0);
    repeat (2) @(negedge clk);
    checkOutput("pad strict writes", log0.size(), 0);
    checkOutput("pad strict error", m_error[0], 1'b1);
    checkOutput("pad lenient ins", log1[0].ins, 10'h0AA);
    log0.delete(); log1.delete();
    pulse_start();
    applyStimulus(8'h01, 0);
    applyStimulus(8'h12, 0);
    applyStimulus(8'h03, 0);
    repeat (3) @(negedge clk);
    checkOutput("recover adr", log0[0].adr, 8'h00);
    checkOutput("recover ins", log0[0].ins, 10'h312);

    $display("[TB] reset mid-load");
    log0.delete(); log1.delete();
    pulse_start();
    applyStimulus(8'h02, 0);
    applyStimulus(8'h11, 0);
    reset = 1'b1;
    byte_valid = 1'b1;
    byte_data = 8'h01;
    @(negedge clk);
    reset = 1'b0;
    byte_valid = 1'b0;
    checkOutput("reset no write", log0.size(), 0);
    pulse_start();
    applyStimulus(8'h01, 0);
    applyStimulus(8'h22, 0);
    applyStimulus(8'h01, 0);
    repeat (3) @(negedge clk);
    checkOutput("reset reload adr", log0[0].adr, 8'h00);
    checkOutput("reset reload ins", log0[0].ins, 10'h122);

    $display("[TB] 256-instruction wrap");
    log0.delete(); log1.delete();
    pulse_start();
    dut_writes1 = 0;
    applyStimulus(8'h00, 0);
    for (int i = 0; i < 256; i++) begin
      applyStimulus(8'(i), 0);
      applyStimulus(8'(i % 4), 0);
    end
    repeat (3) @(negedge clk);
    checkOutput("wrap model count", log1.size(), 256);
    checkOutput("wrap dut count", dut_writes1, 256);
    checkOutput("wrap adr first", log1[0].adr, 8'hFE);
    checkOutput("wrap adr second", log1[1].adr, 8'hFF);
    checkOutput("wrap adr third", log1[2].adr, 8'h00);
    checkOutput("wrap adr last", log1[255].adr, 8'hFD);
    checkOutput("wrap ins last", log1[255].ins, 10'h3FF);
    checkOutput("wrap lane0 last", log0[255].adr, 8'hFF);
    checkOutput("wrap done", m_done[1], 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog expired at t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
